stack_engine: RTL and testbench
===============================

Name: stack_engine

Overview:
- Sequencing master for the 8051 internal-RAM stack.
- Accepts PUSH, POP, CALL and RET commands from the control unit.
- Owns the stack pointer register and drives internal-RAM read/write strobes at the correct SP-relative addresses.
- Returns popped bytes and return PCs to the core, and applies direct SFR writes to SP (address 81h).

Parameters:
- RST_SP, 8'h07, stack pointer value after reset.
- SFR_SP_ADDR, 8'h81, direct address that writes SP.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- cmd  in  3  0 NOP, 1 PUSH, 2 POP, 3 CALL, 4 RET; codes 5–7 are treated as NOP.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  engine can accept a command this cycle.
- push_data  in  8  byte for PUSH; sampled on accept.
- pc_in  in  16  return address for CALL; sampled on accept.
- wr  in  1  SFR write strobe.
- wr_bit  in  1  write is a bit write; bit writes to SP are ignored.
- wr_addr  in  8  SFR write address.
- wr_data  in  8  SFR write data.
- ram_addr  out  8  internal-RAM address.
- ram_wr  out  1  RAM write strobe.
- ram_rd  out  1  RAM read strobe; ram_rdata is valid on the following cycle.
- ram_wdata  out  8  RAM write data.
- ram_rdata  in  8  RAM read data.
- pop_data  out  8  last popped byte; holds its value until the next POP.
- pc_out  out  16  last RET address; holds its value until the next RET.
- done  out  1  one-cycle pulse in the final cycle of a command.
- sp_out  out  8  current SP.
- ovf  out  1  sticky flag: SP incremented past FFh.
- unf  out  1  sticky flag: SP decremented below 00h.
- sfr_conflict  out  1  one-cycle pulse: SP SFR write dropped because the engine was busy.

Behaviour:
- Reset values:
  - sp_out = RST_SP.
  - State = IDLE.
  - All strobes, done, sfr_conflict, ovf, unf = 0.
  - pop_data, pc_out, ram_addr, ram_wdata = 0.
- Reset mid-command aborts the command at that edge. No done pulse is produced. No further RAM strobes are issued.
- sp_write = wr & !wr_bit & (wr_addr == SFR_SP_ADDR).
- cmd_ready = (state == IDLE) & !sp_write.
- Accept = cmd_valid & cmd_ready & cmd != NOP.
- SFR write precedence:
  - In IDLE, sp_write loads SP <= wr_data at the edge. It has priority over a command presented in the same cycle; that command is not accepted and must be held.
  - In any non-IDLE state, sp_write is ignored and sfr_conflict pulses.
- 8051 stack semantics: pre-increment on write, post-decrement after read. SP arithmetic is mod 256.
  - FFh + 1 gives 00h and sets ovf.
  - 00h − 1 gives FFh and sets unf.
  - Both flags clear only on reset.
- State sequences (C0 = accept edge):
  - PUSH:
    - C0: SP <= SP+1, latch push_data.
    - C1 (PUSH_W): ram_wr=1, ram_addr=SP, ram_wdata=latched byte, done=1. Return to IDLE.
  - CALL:
    - C0: SP <= SP+1, latch pc_in.
    - C1 (CALL_L): write PC[7:0] at SP, then SP <= SP+1.
    - C2 (CALL_H): write PC[15:8] at SP, done=1.
    - Net SP change is +2.
  - POP:
    - C1 (POP_R): ram_rd=1, ram_addr=SP.
    - C2 (POP_D): pop_data <= ram_rdata, SP <= SP−1, done=1.
  - RET:
    - C1 (RET_RH): read at SP.
    - C2 (RET_DH): pc_out[15:8] <= ram_rdata, SP <= SP−1.
    - C3 (RET_RL): read at SP.
    - C4 (RET_DL): pc_out[7:0] <= ram_rdata, SP <= SP−1, done=1.
    - Net SP change is −2.
- ram_wr and ram_rd are never asserted together, and are asserted only in the states listed above.
- ram_addr and ram_wdata are don't-care when no strobe is asserted; the RTL holds their last values.
- A new command may be accepted in the cycle after done (back-to-back throughput).
- pop_data is written only by POP. pc_out is written only by RET. Each holds its value otherwise.

Test Plan:
- Reset, then PUSH 3Ch:
  - ram_wr at addr 08h, data 3Ch, one cycle after accept.
  - done at the same time; sp_out = 08h.
- CALL pc_in=1234h from SP=07h:
  - Writes 34h@08h, then 12h@09h.
  - sp_out = 09h; done in C2.
- RET from SP=09h with RAM 08h=34h, 09h=12h:
  - Reads 09h then 08h.
  - pc_out = 1234h; sp_out = 07h; done in C4.
- SFR write 81h=FFh, then PUSH 55h:
  - Write at 00h; sp_out = 00h; ovf=1.
- Underflow: SFR write SP=00h, then POP:
  - Read at 00h; sp_out = FFh; unf=1.
- Collisions:
  - wr to 81h with wr_bit=0 while CALL is in CALL_L: sfr_conflict pulses, SP unaffected, CALL completes normally.
  - sp_write coincident with cmd_valid in IDLE: cmd_ready=0 and SP loads.
  - Reset asserted in RET_RL: no done, sp_out = 07h next cycle.

Source files
------------

// File: rtl/stack_engine.sv
// stack_engine: sequencing master for the 8051 internal-RAM stack.
//
// Executes PUSH / POP / CALL / RET against internal RAM using 8051 semantics:
// the stack pointer is pre-incremented before a write and post-decremented
// after a read. It also accepts direct SFR writes to SP.
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   cmd/cmd_valid/ready   command handshake (0 NOP,1 PUSH,2 POP,3 CALL,4 RET)
//   push_data, pc_in      operands sampled on accept
//   wr/wr_bit/wr_addr/... SFR write port; only byte writes to SFR_SP_ADDR matter
//   ram_*                 internal-RAM strobes; read data arrives one cycle later
//   pop_data, pc_out      results of the last POP / RET
//   done                  pulses in the final cycle of a command
//   sp_out, ovf, unf      stack pointer and sticky wrap flags
//   sfr_conflict          pulses when an SP write is dropped while busy
//
// state  | meaning
// -------+--------------------------------------------------
// IDLE   | waiting for a command or SFR write to SP
// PUSH_W | write pushed byte at SP
// CALL_L | write PC low byte at SP, then increment SP
// CALL_H | write PC high byte at SP
// POP_R  | read at SP
// POP_D  | capture popped byte, decrement SP
// RET_RH | read PC high byte at SP
// RET_DH | capture PC high byte, decrement SP
// RET_RL | read PC low byte at SP
// RET_DL | capture PC low byte, decrement SP
module stack_engine #(
    parameter logic [7:0] RST_SP      = 8'h07,
    parameter logic [7:0] SFR_SP_ADDR = 8'h81
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  cmd,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  push_data,
    input  logic [15:0] pc_in,
    input  logic        wr,
    input  logic        wr_bit,
    input  logic [7:0]  wr_addr,
    input  logic [7:0]  wr_data,
    output logic [7:0]  ram_addr,
    output logic        ram_wr,
    output logic        ram_rd,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata,
    output logic [7:0]  pop_data,
    output logic [15:0] pc_out,
    output logic        done,
    output logic [7:0]  sp_out,
    output logic        ovf,
    output logic        unf,
    output logic        sfr_conflict
);

    localparam logic [2:0] CMD_PUSH = 3'd1;
    localparam logic [2:0] CMD_POP  = 3'd2;
    localparam logic [2:0] CMD_CALL = 3'd3;
    localparam logic [2:0] CMD_RET  = 3'd4;

    typedef enum logic [3:0] {
        IDLE, PUSH_W, CALL_L, CALL_H, POP_R, POP_D,
        RET_RH, RET_DH, RET_RL, RET_DL
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  sp_q, sp_d;
    logic [15:0] data_q, data_d;      // latched push byte or call PC
    logic [7:0]  pop_q, pop_d;
    logic [15:0] pc_q, pc_d;
    logic        ovf_q, ovf_d;
    logic        unf_q, unf_d;
    logic [7:0]  ram_addr_q;
    logic [7:0]  ram_wdata_q;
    logic [7:0]  wbyte;
    logic [7:0]  sp_inc, sp_dec;
    logic        sp_write;

    always_comb begin
        state_d      = state_q;
        sp_d         = sp_q;
        data_d       = data_q;
        pop_d        = pop_q;
        pc_d         = pc_q;
        ovf_d        = ovf_q;
        unf_d        = unf_q;
        ram_wr       = 1'b0;
        ram_rd       = 1'b0;
        done         = 1'b0;
        wbyte        = 8'h00;
        sp_inc       = sp_q + 8'd1;
        sp_dec       = sp_q - 8'd1;
        sp_write     = wr & ~wr_bit & (wr_addr == SFR_SP_ADDR);
        cmd_ready    = (state_q == IDLE) & ~sp_write;
        sfr_conflict = sp_write & (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (sp_write) begin
                    sp_d = wr_data;
                end else if (cmd_valid) begin
                    case (cmd)
                        CMD_PUSH: begin
                            state_d = PUSH_W;
                            sp_d    = sp_inc;
                            ovf_d   = ovf_q | (sp_q == 8'hFF);
                            data_d  = {8'h00, push_data};
                        end
                        CMD_CALL: begin
                            state_d = CALL_L;
                            sp_d    = sp_inc;
                            ovf_d   = ovf_q | (sp_q == 8'hFF);
                            data_d  = pc_in;
                        end
                        CMD_POP:  state_d = POP_R;
                        CMD_RET:  state_d = RET_RH;
                        default:  state_d = IDLE;
                    endcase
                end
            end
            PUSH_W: begin
                ram_wr  = 1'b1;
                wbyte   = data_q[7:0];
                done    = 1'b1;
                state_d = IDLE;
            end
            CALL_L: begin
                ram_wr  = 1'b1;
                wbyte   = data_q[7:0];
                sp_d    = sp_inc;
                ovf_d   = ovf_q | (sp_q == 8'hFF);
                state_d = CALL_H;
            end
            CALL_H: begin
                ram_wr  = 1'b1;
                wbyte   = data_q[15:8];
                done    = 1'b1;
                state_d = IDLE;
            end
            POP_R: begin
                ram_rd  = 1'b1;
                state_d = POP_D;
            end
            POP_D: begin
                pop_d   = ram_rdata;
                sp_d    = sp_dec;
                unf_d   = unf_q | (sp_q == 8'h00);
                done    = 1'b1;
                state_d = IDLE;
            end
            RET_RH: begin
                ram_rd  = 1'b1;
                state_d = RET_DH;
            end
            RET_DH: begin
                pc_d    = {ram_rdata, pc_q[7:0]};
                sp_d    = sp_dec;
                unf_d   = unf_q | (sp_q == 8'h00);
                state_d = RET_RL;
            end
            RET_RL: begin
                ram_rd  = 1'b1;
                state_d = RET_DL;
            end
            RET_DL: begin
                pc_d    = {pc_q[15:8], ram_rdata};
                sp_d    = sp_dec;
                unf_d   = unf_q | (sp_q == 8'h00);
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Address and write data hold their last driven values between strobes.
        ram_addr  = (ram_wr | ram_rd) ? sp_q : ram_addr_q;
        ram_wdata = ram_wr ? wbyte : ram_wdata_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            sp_q        <= RST_SP;
            data_q      <= 16'h0000;
            pop_q       <= 8'h00;
            pc_q        <= 16'h0000;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            ram_addr_q  <= 8'h00;
            ram_wdata_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            sp_q        <= sp_d;
            data_q      <= data_d;
            pop_q       <= pop_d;
            pc_q        <= pc_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            ram_addr_q  <= ram_addr;
            ram_wdata_q <= ram_wdata;
        end
    end

    assign sp_out   = sp_q;
    assign pop_data = pop_q;
    assign pc_out   = pc_q;
    assign ovf      = ovf_q;
    assign unf      = unf_q;

endmodule

// File: tb/tb_stack_engine.sv
// Testbench for stack_engine: directed commands with hand-computed expectations
// pushed into queues; a negedge monitor pops and compares on every RAM strobe,
// done pulse and sfr_conflict pulse.
module tb_stack_engine;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  cmd = 3'd0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  push_data = 8'h00;
    logic [15:0] pc_in = 16'h0000;
    logic        wr = 1'b0;
    logic        wr_bit = 1'b0;
    logic [7:0]  wr_addr = 8'h00;
    logic [7:0]  wr_data = 8'h00;
    logic [7:0]  ram_addr;
    logic        ram_wr;
    logic        ram_rd;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = 8'h00;
    logic [7:0]  pop_data;
    logic [15:0] pc_out;
    logic        done;
    logic [7:0]  sp_out;
    logic        ovf;
    logic        unf;
    logic        sfr_conflict;

    stack_engine dut (
        .clock(clock), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .push_data(push_data), .pc_in(pc_in),
        .wr(wr), .wr_bit(wr_bit), .wr_addr(wr_addr), .wr_data(wr_data),
        .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_rd(ram_rd),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .pop_data(pop_data),
        .pc_out(pc_out), .done(done), .sp_out(sp_out), .ovf(ovf), .unf(unf),
        .sfr_conflict(sfr_conflict)
    );

    always #5 clock = ~clock;

    // Internal RAM model: synchronous write, read data valid the next cycle.
    logic [7:0] mem [256] = '{default: 8'h00};
    always @(posedge clock) begin
        if (ram_wr) mem[ram_addr] <= ram_wdata;
        if (ram_rd) ram_rdata <= mem[ram_addr];
    end

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_wr_q   [$];   // {addr, data}
    logic [7:0]  exp_rd_q   [$];   // addr
    logic [33:0] exp_done_q [$];   // {sp, pop_data, pc_out, ovf, unf} after done
    int          exp_conf_cnt = 0;
    logic        mon_en = 1'b0;

    logic [7:0]  e_pop = 8'h00;
    logic [15:0] e_pc  = 16'h0000;
    logic        e_ovf = 1'b0;
    logic        e_unf = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_done(input logic [7:0] sp);
        exp_done_q.push_back({sp, e_pop, e_pc, e_ovf, e_unf});
    endtask

    // Monitor
    initial begin
        logic done_chk;
        logic [33:0] e;
        done_chk = 1'b0;
        forever begin
            @(negedge clock);
            if (mon_en) begin
                if (done_chk) begin
                    done_chk = 1'b0;
                    e = exp_done_q.pop_front();
                    chk("after_done", {sp_out, pop_data, pc_out, ovf, unf}, e);
                end
                if (ram_wr && ram_rd) chk("wr_rd_overlap", 1, 0);
                if (ram_wr) begin
                    if (exp_wr_q.size() == 0) chk("unexpected_ram_wr", {ram_addr, ram_wdata}, 0);
                    else chk("ram_write", {ram_addr, ram_wdata}, exp_wr_q.pop_front());
                end
                if (ram_rd) begin
                    if (exp_rd_q.size() == 0) chk("unexpected_ram_rd", ram_addr, 0);
                    else chk("ram_read_addr", ram_addr, exp_rd_q.pop_front());
                end
                if (sfr_conflict) begin
                    chk("sfr_conflict_expected", exp_conf_cnt > 0, 1);
                    if (exp_conf_cnt > 0) exp_conf_cnt--;
                end
                if (done) begin
                    if (exp_done_q.size() == 0) chk("unexpected_done", done, 0);
                    else done_chk = 1'b1;
                end
            end
        end
    end

    task automatic sfr_write(input logic [7:0] addr, input logic [7:0] data, input logic bit_wr);
        @(negedge clock);
        wr = 1'b1; wr_addr = addr; wr_data = data; wr_bit = bit_wr;
        @(posedge clock);
        #1 wr = 1'b0; wr_bit = 1'b0;
    endtask

    // Presents a command, waits (bounded) for acceptance. With conf set, drives
    // a byte write to SP in the first busy cycle.
    task automatic issue(input logic [2:0] c, input logic [7:0] d, input logic [15:0] pc, input logic conf);
        int n;
        @(negedge clock);
        cmd = c; push_data = d; pc_in = pc; cmd_valid = 1'b1;
        #1;
        n = 0;
        while (!cmd_ready && n < 30) begin
            @(negedge clock); #1; n++;
        end
        if (n >= 30) chk("accept_timeout", n, 0);
        @(posedge clock);
        #1 cmd_valid = 1'b0;
        if (conf) begin
            wr = 1'b1; wr_addr = 8'h81; wr_data = 8'h55; wr_bit = 1'b0;
            exp_conf_cnt++;
            @(posedge clock);
            #1 wr = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clock);
        while (!cmd_ready && n < 30) begin
            @(negedge clock); n++;
        end
        if (n >= 30) chk("idle_timeout", n, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        e_pop = 8'h00; e_pc = 16'h0000; e_ovf = 1'b0; e_unf = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        @(negedge clock);
        chk("rst_sp", sp_out, 8'h07);
        chk("rst_strobes", {ram_wr, ram_rd, done, sfr_conflict, ovf, unf}, 6'b0);
        chk("rst_data", {pop_data, pc_out, ram_addr, ram_wdata}, 40'h0);
        chk("rst_ready", cmd_ready, 1);
        mon_en = 1'b1;

        // PUSH 3Ch from reset SP
        exp_wr_q.push_back({8'h08, 8'h3C}); exp_done(8'h08);
        issue(3'd1, 8'h3C, 16'h0, 1'b0); wait_idle();

        // CALL 1234h from SP=07h
        sfr_write(8'h81, 8'h07, 1'b0);
        exp_wr_q.push_back({8'h08, 8'h34}); exp_wr_q.push_back({8'h09, 8'h12}); exp_done(8'h09);
        issue(3'd3, 8'h00, 16'h1234, 1'b0); wait_idle();

        // RET back from SP=09h
        exp_rd_q.push_back(8'h09); exp_rd_q.push_back(8'h08);
        e_pc = 16'h1234; exp_done(8'h07);
        issue(3'd4, 8'h00, 16'h0, 1'b0); wait_idle();

        // Overflow: SP=FFh then PUSH 55h
        sfr_write(8'h81, 8'hFF, 1'b0);
        exp_wr_q.push_back({8'h00, 8'h55}); e_ovf = 1'b1; exp_done(8'h00);
        issue(3'd1, 8'h55, 16'h0, 1'b0); wait_idle();

        // Underflow: SP=00h then POP (reads the 55h just written)
        sfr_write(8'h81, 8'h00, 1'b0);
        exp_rd_q.push_back(8'h00); e_pop = 8'h55; e_unf = 1'b1; exp_done(8'hFF);
        issue(3'd2, 8'h00, 16'h0, 1'b0); wait_idle();

        // Back-to-back PUSH / POP round trip; NOP code 5 ignored in between
        sfr_write(8'h81, 8'h20, 1'b0);
        exp_wr_q.push_back({8'h21, 8'hA5}); exp_done(8'h21);
        issue(3'd1, 8'hA5, 16'h0, 1'b0);
        exp_rd_q.push_back(8'h21);
        issue(3'd2, 8'h00, 16'h0, 1'b0);
        e_pop = 8'hA5; exp_done(8'h20);
        wait_idle();
        issue(3'd5, 8'h00, 16'h0, 1'b0);
        @(negedge clock);
        chk("nop_no_effect", {sp_out, cmd_ready}, {8'h20, 1'b1});

        // Bit write and non-SP address must not touch SP
        sfr_write(8'h81, 8'h99, 1'b1);
        sfr_write(8'h80, 8'h99, 1'b0);
        @(negedge clock);
        chk("ignored_sfr_writes", sp_out, 8'h20);

        // SP write during CALL_L is dropped with a conflict pulse
        sfr_write(8'h81, 8'h07, 1'b0);
        exp_wr_q.push_back({8'h08, 8'hEF}); exp_wr_q.push_back({8'h09, 8'hBE}); exp_done(8'h09);
        issue(3'd3, 8'h00, 16'hBEEF, 1'b1); wait_idle();

        // SP write coincident with a command in IDLE wins; command held and accepted next
        @(negedge clock);
        cmd = 3'd1; push_data = 8'h77; cmd_valid = 1'b1;
        wr = 1'b1; wr_addr = 8'h81; wr_data = 8'h40; wr_bit = 1'b0;
        #1 chk("coincident_ready_low", cmd_ready, 0);
        exp_wr_q.push_back({8'h41, 8'h77}); exp_done(8'h41);
        @(posedge clock);
        #1 wr = 1'b0;
        chk("coincident_sp_load", sp_out, 8'h40);
        #1 chk("coincident_ready_high", cmd_ready, 1);
        @(posedge clock);
        #1 cmd_valid = 1'b0;
        wait_idle();

        // Reset in RET_RL: no done, SP back to reset value
        sfr_write(8'h81, 8'h09, 1'b0);
        exp_rd_q.push_back(8'h09); exp_rd_q.push_back(8'h08);
        issue(3'd4, 8'h00, 16'h0, 1'b0);   // now in RET_RH
        @(posedge clock);                  // RET_DH
        @(posedge clock);                  // RET_RL
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        e_pop = 8'h00; e_pc = 16'h0000; e_ovf = 1'b0; e_unf = 1'b0;
        @(negedge clock);
        chk("abort_state", {sp_out, cmd_ready, done, ram_rd, ovf, unf}, {8'h07, 1'b1, 4'b0});
        chk("abort_regs", {pop_data, pc_out}, 24'h0);

        // Normal operation after abort
        exp_wr_q.push_back({8'h08, 8'h3C}); exp_done(8'h08);
        issue(3'd1, 8'h3C, 16'h0, 1'b0); wait_idle();

        repeat (4) @(negedge clock);
        chk("pending_writes", exp_wr_q.size(), 0);
        chk("pending_reads", exp_rd_q.size(), 0);
        chk("pending_dones", exp_done_q.size(), 0);
        chk("pending_conflicts", exp_conf_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
